fetch_mem_seq: RTL and testbench
================================

Name: fetch_mem_seq

Overview:
- Top-level instruction sequencer for the simple 9-bit processor.
- Fetches each instruction from memory via the PC (R7) and the ADDR register, loads IR and decodes the opcode.
- Executes LD, ST and MVNZ itself.
- Hands MV/MVI/ADD/SUB to the existing ALU/register control unit through a start/done handshake, then sequences the next fetch.

Parameters:
- MEM_LAT, 1, memory read latency in cycles between ADDR load and valid data on din (legal range 1..7).
- PC_REG, 7, register index used as program counter.

Ports:
- clock  in  1  system clock, all state changes on rising edge
- resetn  in  1  synchronous, active-high reset
- run  in  1  level; enables fetch of a new instruction
- ir  in  9  IR register contents, III XXX YYY; sampled in DECODE
- g_nz  in  1  high when G register is non-zero; sampled in MVNZ state
- exec_done  in  1  one-cycle pulse from ALU control unit: delegated instruction finished
- reg_out_sel  out  3  register index driven onto bus
- reg_out_en  out  1  enable for reg_out_sel
- reg_in_sel  out  3  register index loaded from bus
- reg_in_en  out  1  enable for reg_in_sel
- din_out  out  1  memory data onto bus
- addr_in  out  1  load ADDR register from bus
- dout_in  out  1  load DOUT register from bus
- w_d  out  1  memory write enable
- incr_pc  out  1  increment R7
- ir_in  out  1  load IR from din
- exec_start  out  1  one-cycle start pulse to ALU control unit
- done  out  1  one-cycle pulse, instruction complete
- illegal  out  1  one-cycle pulse, opcode 111 decoded
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: synchronous, active-high. Sampled high at an edge: next state IDLE, latency counter 0, latched X/Y cleared. All outputs are 0 in IDLE. Reset overrides every other input in every state.
- Outputs: Moore, decoded from current state plus latched X/Y. The only exception is reg_in_en/reg_out_en in MVNZ, which also depend on g_nz.
- States and outputs:
  - IDLE: run=1 -> F_ADDR; run=0 -> stay.
  - F_ADDR: reg_out_sel=PC_REG, reg_out_en, addr_in -> F_WAIT.
  - F_WAIT: incr_pc on the first cycle only. Stays MEM_LAT cycles (counter) -> F_IR.
  - F_IR: ir_in -> DECODE.
  - DECODE: latch X=ir[5:3], Y=ir[2:0], branch on ir[8:6]:
    - 000/001/010/011 -> EXEC
    - 100 -> LD_ADDR
    - 101 -> ST_ADDR
    - 110 -> MVNZ
    - 111 -> FIN with illegal=1
  - EXEC: exec_start=1 on the first cycle only. Waits for exec_done; exec_done=1 -> FIN. No timeout. exec_done outside EXEC is ignored.
  - LD_ADDR: reg_out_sel=Y, reg_out_en, addr_in -> LD_WAIT.
  - LD_WAIT: MEM_LAT cycles -> LD_DATA.
  - LD_DATA: din_out, reg_in_sel=X, reg_in_en -> FIN.
  - ST_ADDR: reg_out_sel=Y, reg_out_en, addr_in -> ST_DATA.
  - ST_DATA: reg_out_sel=X, reg_out_en, dout_in -> ST_WR.
  - ST_WR: w_d=1 (ADDR/DOUT now stable) -> FIN.
  - MVNZ: if g_nz: reg_out_sel=Y, reg_out_en, reg_in_sel=X, reg_in_en. Otherwise no enables. -> FIN.
  - FIN: done=1. run=1 -> F_ADDR (back-to-back); run=0 -> IDLE.
- Sequencing rules:
  - run is sampled only in IDLE and FIN. Deasserting run mid-instruction lets the instruction complete.
  - X or Y = 7 is legal. The PC is an ordinary register for LD/ST/MVNZ; e.g. LD R7 performs a jump.
  - At most one of reg_in_en and w_d is high per cycle; never two bus drivers in one cycle.
- Latency, MEM_LAT=1, run held high:
  - Fetch+decode: 4 cycles.
  - Per-instruction totals: LD 8, ST 8, MVNZ 6, illegal 5, delegated 5+k where k = cycles from exec_start to exec_done inclusive.

Decomposition:
- proc_pkg holds:
  - opcode constants MV..MVNZ and ILL=111;
  - register index constants, PC=7;
  - state enumeration, 4-bit encoding;
  - MEM_LAT bounds.
- One sub-module, lat_counter: 3-bit down-counter with load, dec and zero flag. Shared by F_WAIT and LD_WAIT.

Test Plan:
- Fetch + MVI: resetn pulse, run=1, ir=001_010_000.
  - Cycles 1-4: F_ADDR (out_sel=7, addr_in), F_WAIT (incr_pc), F_IR (ir_in), DECODE.
  - Cycle 5: exec_start=1.
  - exec_done returned 1 cycle later -> done on the following cycle; no reg enables from this block.
- LD r1,[r3] (ir=100_001_011):
  - LD_ADDR: out_sel=3 with addr_in.
  - LD_WAIT: 1 idle cycle.
  - LD_DATA: din_out, in_sel=1, reg_in_en.
  - Then done; total 8 cycles.
- ST r4,[r5] (ir=101_100_101):
  - ST_ADDR: out_sel=5 with addr_in.
  - ST_DATA: out_sel=4 with dout_in.
  - ST_WR: w_d=1 for exactly one cycle.
  - Then done.
- MVNZ r0,r6 (ir=110_000_110):
  - g_nz=0 -> reg_in_en=0, done.
  - g_nz=1 -> out_sel=6, in_sel=0, both enables, done.
- Illegal opcode ir=111_xxx_xxx -> illegal and done in the same cycle, 5 cycles after start; no reg_in_en, w_d or exec_start.
- Reset mid-EXEC: resetn=1 for 1 cycle while waiting for exec_done.
  - Next cycle: IDLE, all outputs 0.
  - A later exec_done pulse is ignored.
  - With run=1 after reset, fetch restarts at F_ADDR.

Source files
------------

// File: rtl/fetch_mem_seq_pkg.sv
// Shared definitions for the 9-bit processor instruction sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_mem_seq_pkg;

    // Opcodes, instruction field III
    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    // Register index used as program counter
    localparam logic [2:0] REG_PC = 3'd7;

    // Legal memory read latency range (3-bit latency counter)
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_F_ADDR  = 4'd1,
        S_F_WAIT  = 4'd2,
        S_F_IR    = 4'd3,
        S_DECODE  = 4'd4,
        S_EXEC    = 4'd5,
        S_LD_ADDR = 4'd6,
        S_LD_WAIT = 4'd7,
        S_LD_DATA = 4'd8,
        S_ST_ADDR = 4'd9,
        S_ST_DATA = 4'd10,
        S_ST_WR   = 4'd11,
        S_MVNZ    = 4'd12,
        S_FIN     = 4'd13
    } state_e;

    // Registered control word driven by the sequencer
    typedef struct packed {
        logic [2:0] reg_out_sel;
        logic       reg_out_en;
        logic [2:0] reg_in_sel;
        logic       reg_in_en;
        logic       din_out;
        logic       addr_in;
        logic       dout_in;
        logic       w_d;
        logic       incr_pc;
        logic       ir_in;
        logic       exec_start;
        logic       done;
        logic       illegal;
        logic       busy;
    } ctrl_t;

    // Clamp a requested latency into the counter's legal range
    function automatic int clamp_lat(input int lat);
        if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
        if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/fetch_mem_seq_if.sv
// Sequencer <-> datapath control bundle (run/ir/status in, bus controls out).
// Latency: n/a (wires only).
// Backpressure: exec_start/exec_done handshake; the sequencer waits indefinitely.
interface fetch_mem_seq_if;
    logic       run;
    logic [8:0] ir;
    logic       g_nz;
    logic       exec_done;
    logic [2:0] reg_out_sel;
    logic       reg_out_en;
    logic [2:0] reg_in_sel;
    logic       reg_in_en;
    logic       din_out;
    logic       addr_in;
    logic       dout_in;
    logic       w_d;
    logic       incr_pc;
    logic       ir_in;
    logic       exec_start;
    logic       done;
    logic       illegal;
    logic       busy;

    modport master (
        input  run, ir, g_nz, exec_done,
        output reg_out_sel, reg_out_en, reg_in_sel, reg_in_en,
               din_out, addr_in, dout_in, w_d, incr_pc, ir_in,
               exec_start, done, illegal, busy
    );

    modport slave (
        output run, ir, g_nz, exec_done,
        input  reg_out_sel, reg_out_en, reg_in_sel, reg_in_en,
               din_out, addr_in, dout_in, w_d, incr_pc, ir_in,
               exec_start, done, illegal, busy
    );
endinterface

// File: rtl/fetch_mem_seq_lat_counter.sv
// 3-bit down-counter timing memory read latency (load, decrement, zero flag).
// Latency: zero flag reflects the registered count; load takes effect next cycle.
// Backpressure: none; decrement saturates at zero.
module fetch_mem_seq_lat_counter
    import fetch_mem_seq_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Next count: load wins over decrement, decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // Count register with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (resetn) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/fetch_mem_seq.sv
// Instruction fetch/decode sequencer; runs LD/ST/MVNZ, delegates MV/MVI/ADD/SUB.
// Latency: fetch+decode 4 cycles at MEM_LAT=1; LD/ST 8, MVNZ 6, illegal 5, delegated 5+k.
// Backpressure: waits in EXEC for exec_done with no timeout; run only sampled in IDLE/FIN.
module fetch_mem_seq
    import fetch_mem_seq_pkg::*;
#(
    parameter int         MEM_LAT = 1,
    parameter logic [2:0] PC_REG  = REG_PC
) (
    input  logic          clock,
    input  logic          resetn,
    fetch_mem_seq_if.master bus
);

    // Counter preload: the wait state lasts MEM_LAT cycles, leaving on zero
    localparam int         LAT_EFF  = clamp_lat(MEM_LAT);
    localparam logic [2:0] LAT_LOAD = 3'(LAT_EFF - 1);

    state_e     state_q, state_d;
    logic [2:0] x_q, x_d;
    logic [2:0] y_q, y_d;
    ctrl_t      ctrl_q, ctrl_d;

    logic       lat_load;
    logic       lat_dec;
    logic       lat_zero;
    logic [2:0] opcode;
    logic       mvnz_move;

    assign opcode = bus.ir[8:6];

    // Counter is preloaded on the address cycle and runs down in the wait state
    assign lat_load = (state_q == S_F_ADDR) || (state_q == S_LD_ADDR);
    assign lat_dec  = (state_q == S_F_WAIT) || (state_q == S_LD_WAIT);

    fetch_mem_seq_lat_counter u_lat (
        .clock      (clock),
        .resetn     (resetn),
        .load_i     (lat_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (lat_dec),
        .zero_o     (lat_zero)
    );

    // Next state and operand latches
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE:    if (bus.run) state_d = S_F_ADDR;
            S_F_ADDR:  state_d = S_F_WAIT;
            S_F_WAIT:  if (lat_zero) state_d = S_F_IR;
            S_F_IR:    state_d = S_DECODE;
            S_DECODE: begin
                x_d = bus.ir[5:3];
                y_d = bus.ir[2:0];
                case (opcode)
                    OP_MV, OP_MVI, OP_ADD, OP_SUB: state_d = S_EXEC;
                    OP_LD:   state_d = S_LD_ADDR;
                    OP_ST:   state_d = S_ST_ADDR;
                    OP_MVNZ: state_d = S_MVNZ;
                    OP_ILL:  state_d = S_FIN;
                    default: state_d = S_FIN;
                endcase
            end
            S_EXEC:    if (bus.exec_done) state_d = S_FIN;
            S_LD_ADDR: state_d = S_LD_WAIT;
            S_LD_WAIT: if (lat_zero) state_d = S_LD_DATA;
            S_LD_DATA: state_d = S_FIN;
            S_ST_ADDR: state_d = S_ST_DATA;
            S_ST_DATA: state_d = S_ST_WR;
            S_ST_WR:   state_d = S_FIN;
            S_MVNZ:    state_d = S_FIN;
            S_FIN:     state_d = bus.run ? S_F_ADDR : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Control word for the state being entered, so outputs come straight from flops
    always_comb begin
        ctrl_d      = '0;
        ctrl_d.busy = (state_d != S_IDLE);
        case (state_d)
            S_F_ADDR: begin
                ctrl_d.reg_out_sel = PC_REG;
                ctrl_d.reg_out_en  = 1'b1;
                ctrl_d.addr_in     = 1'b1;
            end
            // PC bumps once, on entry to the wait, not on every wait cycle
            S_F_WAIT:  ctrl_d.incr_pc = (state_q != S_F_WAIT);
            S_F_IR:    ctrl_d.ir_in = 1'b1;
            S_EXEC:    ctrl_d.exec_start = (state_q != S_EXEC);
            S_LD_ADDR: begin
                ctrl_d.reg_out_sel = y_d;
                ctrl_d.reg_out_en  = 1'b1;
                ctrl_d.addr_in     = 1'b1;
            end
            S_LD_DATA: begin
                ctrl_d.din_out    = 1'b1;
                ctrl_d.reg_in_sel = x_d;
                ctrl_d.reg_in_en  = 1'b1;
            end
            S_ST_ADDR: begin
                ctrl_d.reg_out_sel = y_d;
                ctrl_d.reg_out_en  = 1'b1;
                ctrl_d.addr_in     = 1'b1;
            end
            S_ST_DATA: begin
                ctrl_d.reg_out_sel = x_d;
                ctrl_d.reg_out_en  = 1'b1;
                ctrl_d.dout_in     = 1'b1;
            end
            S_ST_WR:   ctrl_d.w_d = 1'b1;
            // Selects only; enables are qualified by g_nz while in MVNZ
            S_MVNZ: begin
                ctrl_d.reg_out_sel = y_d;
                ctrl_d.reg_in_sel  = x_d;
            end
            S_FIN: begin
                ctrl_d.done    = 1'b1;
                // DECODE only jumps straight to FIN for the illegal opcode
                ctrl_d.illegal = (state_q == S_DECODE);
            end
            default: ;
        endcase
    end

    // Sequencer state, operand latches and registered control outputs
    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q <= S_IDLE;
            x_q     <= 3'd0;
            y_q     <= 3'd0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign mvnz_move = (state_q == S_MVNZ) && bus.g_nz;

    assign bus.reg_out_sel = ctrl_q.reg_out_sel;
    assign bus.reg_out_en  = ctrl_q.reg_out_en | mvnz_move;
    assign bus.reg_in_sel  = ctrl_q.reg_in_sel;
    assign bus.reg_in_en   = ctrl_q.reg_in_en | mvnz_move;
    assign bus.din_out     = ctrl_q.din_out;
    assign bus.addr_in     = ctrl_q.addr_in;
    assign bus.dout_in     = ctrl_q.dout_in;
    assign bus.w_d         = ctrl_q.w_d;
    assign bus.incr_pc     = ctrl_q.incr_pc;
    assign bus.ir_in       = ctrl_q.ir_in;
    assign bus.exec_start  = ctrl_q.exec_start;
    assign bus.done        = ctrl_q.done;
    assign bus.illegal     = ctrl_q.illegal;
    assign bus.busy        = ctrl_q.busy;

endmodule

// File: tb/tb_fetch_mem_seq.sv
// Directed bench for the fetch/decode sequencer at MEM_LAT=1.
// Latency: checks every cycle of each instruction against hand-built tables.
// Backpressure: exec_done returned by the bench at fixed cycle offsets.
module tb_fetch_mem_seq;

    logic clock = 1'b0;
    logic resetn;

    fetch_mem_seq_if bus();

    fetch_mem_seq #(
        .MEM_LAT (1),
        .PC_REG  (3'd7)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Flag bit order: din_out addr_in dout_in w_d incr_pc ir_in exec_start done illegal busy
    localparam logic [9:0] FL_DIN  = 10'b10_0000_0000;
    localparam logic [9:0] FL_ADDR = 10'b01_0000_0000;
    localparam logic [9:0] FL_DOUT = 10'b00_1000_0000;
    localparam logic [9:0] FL_WD   = 10'b00_0100_0000;
    localparam logic [9:0] FL_INC  = 10'b00_0010_0000;
    localparam logic [9:0] FL_IRIN = 10'b00_0001_0000;
    localparam logic [9:0] FL_EXS  = 10'b00_0000_1000;
    localparam logic [9:0] FL_DONE = 10'b00_0000_0100;
    localparam logic [9:0] FL_ILL  = 10'b00_0000_0010;
    localparam logic [9:0] FL_BUSY = 10'b00_0000_0001;

    function automatic logic [17:0] mk(input logic [2:0] os, input logic oe,
                                       input logic [2:0] is, input logic ie,
                                       input logic [9:0] fl);
        return {os, oe, is, ie, fl};
    endfunction

    function automatic logic [17:0] snap();
        return {bus.reg_out_sel, bus.reg_out_en, bus.reg_in_sel, bus.reg_in_en,
                bus.din_out, bus.addr_in, bus.dout_in, bus.w_d, bus.incr_pc,
                bus.ir_in, bus.exec_start, bus.done, bus.illegal, bus.busy};
    endfunction

    // Expected outputs for fetch cycles 1..4 (F_ADDR, F_WAIT, F_IR, DECODE)
    function automatic logic [17:0] fetch_exp(input int c);
        case (c)
            1:       return mk(3'd7, 1'b1, 3'd0, 1'b0, FL_ADDR | FL_BUSY);
            2:       return mk(3'd0, 1'b0, 3'd0, 1'b0, FL_INC | FL_BUSY);
            3:       return mk(3'd0, 1'b0, 3'd0, 1'b0, FL_IRIN | FL_BUSY);
            4:       return mk(3'd0, 1'b0, 3'd0, 1'b0, FL_BUSY);
            default: return 18'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [8:0] instr);
        bus.ir  = instr;
        bus.run = 1'b1;
    endtask

    task automatic test_reset();
        logic [17:0] got;
        resetn = 1'b1;
        step();
        step();
        got = snap();
        checks++;
        if (got !== 18'd0) begin
            errors++;
            $display("FAIL reset_idle got %05h expected %05h", got, 18'd0);
        end
        bus.run = 1'b1;
        step();
        got = snap();
        checks++;
        if (got !== 18'd0) begin
            errors++;
            $display("FAIL reset_overrides_run got %05h expected %05h", got, 18'd0);
        end
        resetn  = 1'b0;
        bus.run = 1'b0;
        step();
        step();
        got = snap();
        checks++;
        if (got !== 18'd0) begin
            errors++;
            $display("FAIL idle_holds got %05h expected %05h", got, 18'd0);
        end
    endtask

    task automatic test_mvi();
        logic [17:0] tbl [8];
        logic [17:0] got;
        tbl = '{fetch_exp(1), fetch_exp(2), fetch_exp(3), fetch_exp(4),
                mk(3'd0, 1'b0, 3'd0, 1'b0, FL_EXS | FL_BUSY),
                mk(3'd0, 1'b0, 3'd0, 1'b0, FL_BUSY),
                mk(3'd0, 1'b0, 3'd0, 1'b0, FL_DONE | FL_BUSY),
                18'd0};
        start(9'b001_010_000);
        for (int c = 0; c < 8; c++) begin
            step();
            got = snap();
            checks++;
            if (got !== tbl[c]) begin
                errors++;
                $display("FAIL mvi cycle %0d got %05h expected %05h", c + 1, got, tbl[c]);
            end
            if (c == 5) bus.exec_done = 1'b1;
            if (c == 6) begin
                bus.exec_done = 1'b0;
                bus.run       = 1'b0;
            end
        end
    endtask

    task automatic test_ld();
        logic [17:0] tbl [9];
        logic [17:0] got;
        tbl = '{fetch_exp(1), fetch_exp(2), fetch_exp(3), fetch_exp(4),
                mk(3'd3, 1'b1, 3'd0, 1'b0, FL_ADDR | FL_BUSY),
                mk(3'd0, 1'b0, 3'd0, 1'b0, FL_BUSY),
                mk(3'd0, 1'b0, 3'd1, 1'b1, FL_DIN | FL_BUSY),
                mk(3'd0, 1'b0, 3'd0, 1'b0, FL_DONE | FL_BUSY),
                18'd0};
        start(9'b100_001_011);
        for (int c = 0; c < 9; c++) begin
            step();
            got = snap();
            checks++;
            if (got !== tbl[c]) begin
                errors++;
                $display("FAIL ld cycle %0d got %05h expected %05h", c + 1, got, tbl[c]);
            end
            // Dropping run mid-instruction must still let the load finish
            if (c == 1) bus.run = 1'b0;
        end
    endtask

    task automatic test_st_back_to_back();
        logic [17:0] tbl [14];
        logic [17:0] got;
        tbl = '{fetch_exp(1), fetch_exp(2), fetch_exp(3), fetch_exp(4),
                mk(3'd5, 1'b1, 3'd0, 1'b0, FL_ADDR | FL_BUSY),
                mk(3'd4, 1'b1, 3'd0, 1'b0, FL_DOUT | FL_BUSY),
                mk(3'd0, 1'b0, 3'd0, 1'b0, FL_WD | FL_BUSY),
                mk(3'd0, 1'b0, 3'd0, 1'b0, FL_DONE | FL_BUSY),
                fetch_exp(1), fetch_exp(2), fetch_exp(3), fetch_exp(4),
                mk(3'd0, 1'b0, 3'd0, 1'b0, FL_DONE | FL_ILL | FL_BUSY),
                18'd0};
        start(9'b101_100_101);
        for (int c = 0; c < 14; c++) begin
            step();
            got = snap();
            checks++;
            if (got !== tbl[c]) begin
                errors++;
                $display("FAIL st_b2b cycle %0d got %05h expected %05h", c + 1, got, tbl[c]);
            end
            if (c == 8)  bus.ir  = 9'b111_000_000;
            if (c == 12) bus.run = 1'b0;
        end
    endtask

    task automatic test_mvnz(input logic gnz);
        logic [17:0] tbl [7];
        logic [17:0] got;
        tbl = '{fetch_exp(1), fetch_exp(2), fetch_exp(3), fetch_exp(4),
                gnz ? mk(3'd6, 1'b1, 3'd0, 1'b1, FL_BUSY)
                    : mk(3'd0, 1'b0, 3'd0, 1'b0, FL_BUSY),
                mk(3'd0, 1'b0, 3'd0, 1'b0, FL_DONE | FL_BUSY),
                18'd0};
        bus.g_nz = gnz;
        start(9'b110_000_110);
        for (int c = 0; c < 7; c++) begin
            step();
            got = snap();
            // With g_nz low only the enables matter; register selects are don't-care
            if (!gnz && c == 4) begin
                got[17:15] = 3'd0;
                got[13:11] = 3'd0;
            end
            checks++;
            if (got !== tbl[c]) begin
                errors++;
                $display("FAIL mvnz_g%0d cycle %0d got %05h expected %05h", gnz, c + 1, got, tbl[c]);
            end
            if (c == 5) bus.run = 1'b0;
        end
        bus.g_nz = 1'b0;
    endtask

    task automatic test_illegal();
        logic [17:0] tbl [6];
        logic [17:0] got;
        tbl = '{fetch_exp(1), fetch_exp(2), fetch_exp(3), fetch_exp(4),
                mk(3'd0, 1'b0, 3'd0, 1'b0, FL_DONE | FL_ILL | FL_BUSY),
                18'd0};
        start(9'b111_101_010);
        for (int c = 0; c < 6; c++) begin
            step();
            got = snap();
            checks++;
            if (got !== tbl[c]) begin
                errors++;
                $display("FAIL illegal cycle %0d got %05h expected %05h", c + 1, got, tbl[c]);
            end
            if (c == 4) bus.run = 1'b0;
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [17:0] tbl [6];
        logic [17:0] got;
        logic [17:0] exp;
        tbl = '{fetch_exp(1), fetch_exp(2), fetch_exp(3), fetch_exp(4),
                mk(3'd0, 1'b0, 3'd0, 1'b0, FL_EXS | FL_BUSY),
                mk(3'd0, 1'b0, 3'd0, 1'b0, FL_BUSY)};
        start(9'b010_011_001);
        for (int c = 0; c < 6; c++) begin
            step();
            got = snap();
            checks++;
            if (got !== tbl[c]) begin
                errors++;
                $display("FAIL rst_exec cycle %0d got %05h expected %05h", c + 1, got, tbl[c]);
            end
        end
        bus.run = 1'b0;
        resetn  = 1'b1;
        step();
        resetn  = 1'b0;
        got = snap();
        checks++;
        if (got !== 18'd0) begin
            errors++;
            $display("FAIL rst_exec_idle got %05h expected %05h", got, 18'd0);
        end
        bus.exec_done = 1'b1;
        step();
        bus.exec_done = 1'b0;
        step();
        got = snap();
        checks++;
        if (got !== 18'd0) begin
            errors++;
            $display("FAIL exec_done_ignored got %05h expected %05h", got, 18'd0);
        end
        bus.run = 1'b1;
        step();
        got = snap();
        exp = fetch_exp(1);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL restart_faddr got %05h expected %05h", got, exp);
        end
        bus.run = 1'b0;
        step();
        got = snap();
        exp = fetch_exp(2);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL restart_fwait got %05h expected %05h", got, exp);
        end
        resetn = 1'b1;
        step();
        resetn = 1'b0;
        step();
    endtask

    initial begin
        resetn        = 1'b1;
        bus.run       = 1'b0;
        bus.ir        = 9'd0;
        bus.g_nz      = 1'b0;
        bus.exec_done = 1'b0;
        test_reset();
        test_mvi();
        test_ld();
        test_st_back_to_back();
        test_mvnz(1'b0);
        test_mvnz(1'b1);
        test_illegal();
        test_reset_mid_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
